// File: rtl/aes_pkg.sv
// Shared AES constants and helpers used by the cipher, decipher and key-expansion blocks.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int KS_W    = 1920;
    localparam int MAX_NR  = 14;

    // Unsupported key lengths fall back to AES-128.
    function automatic logic [3:0] nrFromNk(input logic [7:0] nk);
        case (nk)
            8'd6:    return 4'd12;
            8'd8:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round key r is words 4r..4r+3, packed from the MSB end of the schedule.
    function automatic logic [BLOCK_W-1:0] roundKey(input logic [KS_W-1:0] ks, input logic [3:0] r);
        logic [KS_W-1:0] shiftedKs;
        shiftedKs = ks << (BLOCK_W * int'(r));
        return shiftedKs[KS_W-1 -: BLOCK_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box lookup, one byte wide.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] sub
);

    // Row-major table; entry 0 sits in the top byte, so the index is inverted.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = SBOX_TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/cipher.sv
// Iterative AES encryption core: one full round per clock, round count taken from nk.
module cipher
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         nk,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KS_W-1:0]    key_schedule,
    output logic [BLOCK_W-1:0] data_out,
    output logic               done
);

    // round: 0 = load, 1..nrReg = rounds, nrReg+1 = finished and idle.
    logic [BLOCK_W-1:0] state;
    logic [3:0]         round;
    logic [3:0]         nrReg;
    logic               lastRound;
    logic [7:0]         subBytes [16];
    logic [7:0]         shifted  [16];
    logic [7:0]         mixed    [16];
    logic [BLOCK_W-1:0] preKey;
    logic [BLOCK_W-1:0] roundOut;

    for (genvar i = 0; i < 16; i++) begin : gSbox
        aes_sbox uSbox (
            .value (state[BLOCK_W-1-8*i -: 8]),
            .sub   (subBytes[i])
        );
    end

    // Byte index 4*col+row; row r takes its byte from column (col+r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : gShiftCol
        for (genvar r = 0; r < 4; r++) begin : gShiftRow
            assign shifted[4*c+r] = subBytes[4*((c+r)%4)+r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : gMix
        assign mixed[4*c+0] = xtime(shifted[4*c+0]) ^ xtime(shifted[4*c+1]) ^ shifted[4*c+1]
                            ^ shifted[4*c+2] ^ shifted[4*c+3];
        assign mixed[4*c+1] = shifted[4*c+0] ^ xtime(shifted[4*c+1]) ^ xtime(shifted[4*c+2])
                            ^ shifted[4*c+2] ^ shifted[4*c+3];
        assign mixed[4*c+2] = shifted[4*c+0] ^ shifted[4*c+1] ^ xtime(shifted[4*c+2])
                            ^ xtime(shifted[4*c+3]) ^ shifted[4*c+3];
        assign mixed[4*c+3] = xtime(shifted[4*c+0]) ^ shifted[4*c+0] ^ shifted[4*c+1]
                            ^ shifted[4*c+2] ^ xtime(shifted[4*c+3]);
    end

    assign lastRound = (round == nrReg);

    for (genvar i = 0; i < 16; i++) begin : gPack
        assign preKey[BLOCK_W-1-8*i -: 8] = lastRound ? shifted[i] : mixed[i];
    end

    assign roundOut = preKey ^ roundKey(key_schedule, round);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= '0;
            round    <= 4'd0;
            nrReg    <= 4'd0;
            data_out <= '0;
            done     <= 1'b0;
        end else if (round == 4'd0) begin
            state <= data_in ^ roundKey(key_schedule, 4'd0);
            nrReg <= nrFromNk(nk);
            round <= 4'd1;
        end else if (round <= nrReg) begin
            state <= roundOut;
            round <= round + 4'd1;
            if (lastRound) begin
                data_out <= roundOut;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cipher.sv
// Directed FIPS-197 vector bench for the cipher core with reset and input-stability checks.
module tb_cipher;

    logic          clk;
    logic          reset;
    logic [7:0]    nk;
    logic [127:0]  data_in;
    logic [1919:0] key_schedule;
    logic [127:0]  data_out;
    logic          done;

    int            checks;
    int            failures;
    logic [7:0]    sboxTab [256];
    logic [127:0]  expQ [$];

    cipher dut (
        .clk          (clk),
        .reset        (reset),
        .nk           (nk),
        .data_in      (data_in),
        .key_schedule (key_schedule),
        .data_out     (data_out),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map, used only for key expansion.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nkw);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nkw) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nkw == 0) begin
                    t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end else if (nkw > 6 && i % nkw == 4) begin
                    t = subWord(t);
                end
                w[i] = w[i-nkw] ^ t;
            end
        end
        ks = '0;
        for (int i = 0; i < 60; i++) ks[1919-32*i -: 32] = w[i];
        return ks;
    endfunction

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds reset for two edges with the inputs applied, then releases on a falling edge.
    task automatic prepare(input logic [7:0] nkVal, input int ksNk, input logic [127:0] pt,
                           input logic [255:0] key, input logic [127:0] expCt);
        @(negedge clk);
        reset        = 1'b1;
        nk           = nkVal;
        data_in      = pt;
        key_schedule = expandKey(key, ksNk);
        expQ.push_back(expCt);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges since release, bounded at 20, then scores latency and ciphertext.
    task automatic waitResult(input string tag, input int expEdges);
        int           doneEdge;
        logic [127:0] expCt;
        doneEdge = 0;
        for (int e = 1; e <= 20 && doneEdge == 0; e++) begin
            @(posedge clk);
            #1;
            if (done) doneEdge = e;
            else if (e == expEdges - 1) check({tag, "_pre"}, {done, data_out}, 129'h0);
        end
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            expCt = expQ.pop_front();
            check({tag, "_latency"}, 129'(doneEdge), 129'(expEdges));
            check({tag, "_data"}, {done, data_out}, {1'b1, expCt});
        end
    endtask

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        nk           = 8'd4;
        data_in      = '0;
        key_schedule = '0;
        buildSbox();

        @(posedge clk);
        #1;
        check("reset_first", {done, data_out}, 129'h0);
        repeat (10) @(posedge clk);
        #1;
        check("reset_held", {done, data_out}, 129'h0);

        prepare(8'd4, 4, PT_C, KEY128, CT128);
        waitResult("c1", 11);

        @(negedge clk);
        data_in = 128'hdeadbeefcafef00d0123456789abcdef;
        nk      = 8'd8;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("hold_after_done", {done, data_out}, {1'b1, CT128});
        end

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_after_done", {done, data_out}, 129'h0);

        prepare(8'd4, 4, 128'h3243f6a8885a308d313198a2e0370734,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32);
        waitResult("appb", 11);

        prepare(8'd6, 6, PT_C, KEY192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        waitResult("c2", 13);

        prepare(8'd8, 8, PT_C, KEY256, 128'h8ea2b7ca516745bfeafc49904b496089);
        waitResult("c3", 15);

        prepare(8'd5, 4, PT_C, KEY128, CT128);
        waitResult("nk_invalid", 11);

        prepare(8'd4, 4, PT_C, KEY128, CT128);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mid", {done, data_out}, 129'h0);
        @(negedge clk);
        reset = 1'b0;
        waitResult("c1_restart", 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cipher.md
CIPHER -- requirements
Module: cipher

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset; also serves as "start": held high while inputs are prepared, released to begin encryption.
- nk  input  8  key length in 32-bit words: 4 = AES-128, 6 = AES-192, 8 = AES-256.
- data_in  input  128  plaintext block; byte 0 is bits [127:120], column-major state order per FIPS-197.
- key_schedule  input  1920  expanded key, 60 words; word w[i] at bits [1919-32i -: 32]; round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- data_out  output  128  ciphertext block, same byte order as data_in.
- done  output  1  high when data_out holds a valid ciphertext.

REQ-002 The module SHALL use one clock; reset is synchronous and active-high, with ports named clk and reset.

Function
REQ-003 The module SHALL derive Nr = 10, 12 or 14 for nk = 4, 6 or 8; any other nk value SHALL be treated as nk = 4 (Nr = 10).
REQ-004 On the first rising edge with reset low, it SHALL sample data_in and nk, and load state = data_in XOR round key 0; the round counter SHALL become 1.
REQ-005 On each subsequent edge, while the round counter r is ≤ Nr, it SHALL apply one round: SubBytes, ShiftRows, MixColumns (omitted when r = Nr), then AddRoundKey with round key r. It SHALL then increment r.
REQ-006 On the edge that completes round Nr, it SHALL register data_out = final state and set done = 1. This is Nr+1 edges after reset deasserts: 11, 13 or 15 edges.
REQ-007 After done rises, data_out and done SHALL hold, and no further rounds SHALL execute until reset is asserted again.
REQ-008 data_out SHALL read 128'h0 and done SHALL read 0 at all times before completion.
REQ-009 key_schedule SHALL be read combinationally every round and is required stable from reset deassertion until done. data_in and nk changes after the sampling edge SHALL have no effect.
REQ-010 SubBytes SHALL use the FIPS-197 forward S-box.
REQ-011 ShiftRows SHALL rotate row k left by k bytes.
REQ-012 MixColumns SHALL multiply over GF(2^8) with the polynomial 0x11B, using the matrix rows [02 03 01 01] rotated.
REQ-013 Each round SHALL be combinational between state registers; there SHALL be no multi-cycle paths.

Reset
REQ-014 While reset is high at a clock edge, it SHALL clear state to 0, the round counter to 0, data_out to 0 and done to 0.
REQ-015 Reset asserted mid-encryption SHALL abort the operation on that edge with no output glitch. A fresh encryption SHALL start on the first edge after release.
REQ-016 Reset held high for many cycles SHALL keep all outputs at 0.

Structure
REQ-017 A shared package aes_pkg SHALL hold:
- the constants BLOCK_W = 128, WORD_W = 32, KS_W = 1920 and MAX_NR = 14;
- an Nr-from-nk function;
- an xtime/GF-multiply-by-2 function;
- the round-key extraction function.
These are reused by the sibling decipher and key-expansion blocks.
REQ-018 It SHALL contain one sub-module, aes_sbox: a combinational 8-bit in, 8-bit out forward S-box lookup, instantiated 16 times.
REQ-019 The round counter SHALL be 4 bits wide; the control flow is implicit in the counter: 0 = load, 1..Nr = rounds, Nr+1 = done.

Verification
REQ-020 AES-128 (FIPS-197 C.1):
- Stimulus: nk = 4, data_in = 00112233445566778899aabbccddeeff, schedule expanded from key 000102030405060708090a0b0c0d0e0f.
- Response: data_out = 69c4e0d86a7b0430d8cdb78070b4c55a, with done rising exactly 11 edges after reset release.
REQ-021 AES-192 (FIPS-197 C.2):
- Stimulus: nk = 6, same plaintext, key 000102…1617.
- Response: data_out = dda97ca4864cdfe06eaf70a0ec0d7191, with done at edge 13.
REQ-022 AES-256 (FIPS-197 C.3):
- Stimulus: nk = 8, same plaintext, key 000102…1e1f.
- Response: data_out = 8ea2b7ca516745bfeafc49904b496089, with done at edge 15.
REQ-023 FIPS-197 Appendix B:
- Stimulus: nk = 4, data_in = 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
- Response: data_out = 3925841d02dc09fbdc118597196a0b32.
REQ-024 Reset mid-operation: assert reset at edge 5 of the C.1 run.
- Response: done = 0 and data_out = 0 on the next edge.
- After release, C.1 repeats with the correct result at edge 11.
REQ-025 Input stability after done: after done, change data_in and nk.
- Response: data_out and done remain unchanged for 20 cycles.
